// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: operand bypass, hazard detection, redirect selection,
// per-stage stall/flush control, stall watchdog and saturating perf counters.
module pipeline_hazard_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_FWD       = 2,
  parameter int unsigned RESOLVE_STAGE = 1,
  parameter int unsigned WDOG_LIMIT    = 64,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [4:0]                    rs1Addr,
  input  logic [4:0]                    rs2Addr,
  input  logic                          rs1Used,
  input  logic                          rs2Used,
  input  logic [DATA_WIDTH-1:0]         rs1Data,
  input  logic [DATA_WIDTH-1:0]         rs2Data,
  input  logic [NUM_FWD-1:0]            fwdValid,
  input  logic [NUM_FWD-1:0]            fwdReady,
  input  logic [5*NUM_FWD-1:0]          fwdAddr,
  input  logic [DATA_WIDTH*NUM_FWD-1:0] fwdData,
  input  logic                          fetchPredTaken,
  input  logic [DATA_WIDTH-1:0]         fetchPredTarget,
  input  logic                          resValid,
  input  logic                          resTaken,
  input  logic                          resPred,
  input  logic [DATA_WIDTH-1:0]         resTarget,
  input  logic [DATA_WIDTH-1:0]         resFallthrough,
  input  logic                          mulDivBusy,
  output logic [DATA_WIDTH-1:0]         bypassedRs1,
  output logic [DATA_WIDTH-1:0]         bypassedRs2,
  output logic                          redirect,
  output logic [DATA_WIDTH-1:0]         irregPc,
  output logic [1:0]                    fetchOp,
  output logic [1:0]                    decodeOp,
  output logic [1:0]                    executeOp,
  output logic                          mulDivClear,
  output logic [CNT_WIDTH-1:0]          stallCount,
  output logic [CNT_WIDTH-1:0]          missCount,
  output logic                          watchdogErr
);

  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [1:0] OP_NORMAL = 2'd0;
  localparam logic [1:0] OP_STALL  = 2'd1;
  localparam logic [1:0] OP_FLUSH  = 2'd2;

  logic                  shadow_q, shadow_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  wdog_err_q, wdog_err_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  rs1_not_ready, rs2_not_ready;
  logic                  data_haz, struct_haz, stall_any, miss;

  // Returns {result-not-ready, operand}; lowest-index matching source wins.
  function automatic logic [DATA_WIDTH:0] bypass(input logic [4:0]            addr,
                                                 input logic [DATA_WIDTH-1:0] rf_data);
    logic                found;
    logic [DATA_WIDTH:0] res;
    found = 1'b0;
    res   = {1'b0, rf_data};
    if (addr == 5'd0) begin
      res = '0;
    end else begin
      for (int i = 0; i < int'(NUM_FWD); i++) begin
        if (!found && fwdValid[i] && (fwdAddr[i*5 +: 5] == addr)) begin
          found = 1'b1;
          res   = {!fwdReady[i], fwdData[i*DATA_WIDTH +: DATA_WIDTH]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {rs1_not_ready, bypassedRs1} = bypass(rs1Addr, rs1Data);
    {rs2_not_ready, bypassedRs2} = bypass(rs2Addr, rs2Data);
  end

  assign data_haz   = (rs1Used & rs1_not_ready) | (rs2Used & rs2_not_ready);
  assign struct_haz = mulDivBusy;
  assign stall_any  = struct_haz | data_haz;
  assign miss       = resValid & (resTaken != resPred);

  assign irregPc     = miss ? (resTaken ? resTarget : resFallthrough) : fetchPredTarget;
  assign redirect    = rstN & (miss | (fetchPredTaken & !stall_any));
  assign mulDivClear = miss;

  // Stage control, priority miss > structural > data > predicted-taken shadow.
  always_comb begin
    fetchOp   = OP_NORMAL;
    decodeOp  = OP_NORMAL;
    executeOp = OP_NORMAL;
    if (!rstN) begin
      fetchOp   = OP_FLUSH;
      decodeOp  = OP_FLUSH;
      executeOp = OP_FLUSH;
    end else if (miss) begin
      decodeOp  = OP_FLUSH;
      executeOp = (RESOLVE_STAGE == 2) ? OP_FLUSH : OP_NORMAL;
    end else if (struct_haz) begin
      fetchOp   = OP_STALL;
      decodeOp  = OP_STALL;
      executeOp = OP_STALL;
    end else if (data_haz) begin
      fetchOp   = OP_STALL;
      decodeOp  = OP_STALL;
      executeOp = OP_FLUSH;
    end else if (shadow_q) begin
      decodeOp  = OP_FLUSH;
    end
  end

  // Next-state for shadow, watchdog and counters.
  always_comb begin
    shadow_d    = shadow_q;
    wdog_d      = '0;
    wdog_err_d  = wdog_err_q;
    stall_cnt_d = stall_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (miss) begin
      shadow_d = 1'b0;
    end else if (!stall_any) begin
      shadow_d = fetchPredTaken;
    end
    if (struct_haz && !miss) begin
      wdog_d = (wdog_q == WD_W'(WDOG_LIMIT)) ? wdog_q : wdog_q + WD_W'(1);
    end
    if (wdog_d == WD_W'(WDOG_LIMIT)) begin
      wdog_err_d = 1'b1;
    end
    if (stall_any && !miss && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shadow_q    <= 1'b0;
      wdog_q      <= '0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      shadow_q    <= shadow_d;
      wdog_q      <= wdog_d;
      wdog_err_q  <= wdog_err_d;
      stall_cnt_q <= stall_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign stallCount  = stall_cnt_q;
  assign missCount   = miss_cnt_q;
  assign watchdogErr = wdog_err_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: two configurations (EX resolve with
// 16-bit counters, MEM resolve with 4-bit counters and short watchdog).
module tb_pipeline_hazard_unit;

  localparam int NF = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic [4:0]  rs1Addr, rs2Addr;
  logic        rs1Used, rs2Used;
  logic [31:0] rs1Data, rs2Data;
  logic [1:0]  fwdValid, fwdReady;
  logic [9:0]  fwdAddr;
  logic [63:0] fwdData;
  logic        fetchPredTaken;
  logic [31:0] fetchPredTarget;
  logic        resValid, resTaken, resPred;
  logic [31:0] resTarget, resFallthrough;
  logic        mulDivBusy;

  logic [31:0] a_byp1, a_byp2, a_pc, b_byp1, b_byp2, b_pc;
  logic        a_redir, a_mdc, a_err, b_redir, b_mdc, b_err;
  logic [1:0]  a_fo, a_do, a_eo, b_fo, b_do, b_eo;
  logic [15:0] a_sc, a_mc;
  logic [3:0]  b_sc, b_mc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.DATA_WIDTH(32), .NUM_FWD(2), .RESOLVE_STAGE(1),
                         .WDOG_LIMIT(64), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rstN(rstN), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Used(rs1Used), .rs2Used(rs2Used), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .fwdValid(fwdValid), .fwdReady(fwdReady), .fwdAddr(fwdAddr), .fwdData(fwdData),
    .fetchPredTaken(fetchPredTaken), .fetchPredTarget(fetchPredTarget),
    .resValid(resValid), .resTaken(resTaken), .resPred(resPred),
    .resTarget(resTarget), .resFallthrough(resFallthrough), .mulDivBusy(mulDivBusy),
    .bypassedRs1(a_byp1), .bypassedRs2(a_byp2), .redirect(a_redir), .irregPc(a_pc),
    .fetchOp(a_fo), .decodeOp(a_do), .executeOp(a_eo), .mulDivClear(a_mdc),
    .stallCount(a_sc), .missCount(a_mc), .watchdogErr(a_err));

  pipeline_hazard_unit #(.DATA_WIDTH(32), .NUM_FWD(2), .RESOLVE_STAGE(2),
                         .WDOG_LIMIT(5), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rstN(rstN), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Used(rs1Used), .rs2Used(rs2Used), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .fwdValid(fwdValid), .fwdReady(fwdReady), .fwdAddr(fwdAddr), .fwdData(fwdData),
    .fetchPredTaken(fetchPredTaken), .fetchPredTarget(fetchPredTarget),
    .resValid(resValid), .resTaken(resTaken), .resPred(resPred),
    .resTarget(resTarget), .resFallthrough(resFallthrough), .mulDivBusy(mulDivBusy),
    .bypassedRs1(b_byp1), .bypassedRs2(b_byp2), .redirect(b_redir), .irregPc(b_pc),
    .fetchOp(b_fo), .decodeOp(b_do), .executeOp(b_eo), .mulDivClear(b_mdc),
    .stallCount(b_sc), .missCount(b_mc), .watchdogErr(b_err));

  typedef struct {
    logic [31:0] byp1, byp2, pc, sc, mc;
    logic        redir, mdc, err;
    logic [1:0]  fo, dop, eo;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference state, index 0 = dut_a, 1 = dut_b.
  logic m_sh[2];
  logic m_err[2];
  int   m_wd[2];
  int   m_sc[2];
  int   m_mc[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_bypass(input logic [4:0] a, input logic [31:0] rf,
                                     output logic [31:0] v, output logic nr);
    v  = rf;
    nr = 1'b0;
    if (a == 5'd0) begin
      v = 32'd0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (fwdValid[i] && fwdAddr[i*5 +: 5] == a) begin
          v  = fwdData[i*32 +: 32];
          nr = !fwdReady[i];
          break;
        end
      end
    end
  endfunction

  function automatic void ref_hazards(output logic [31:0] v1, output logic [31:0] v2,
                                      output logic dh, output logic miss);
    logic n1, n2;
    ref_bypass(rs1Addr, rs1Data, v1, n1);
    ref_bypass(rs2Addr, rs2Data, v2, n2);
    dh   = (rs1Used && n1) || (rs2Used && n2);
    miss = resValid && (resTaken != resPred);
  endfunction

  function automatic exp_t predict(input int c);
    exp_t e;
    logic [31:0] v1, v2;
    logic dh, miss;
    ref_hazards(v1, v2, dh, miss);
    e.byp1 = v1;
    e.byp2 = v2;
    e.pc   = miss ? (resTaken ? resTarget : resFallthrough) : fetchPredTarget;
    e.mdc  = miss;
    if (!rstN) begin
      e.redir = 1'b0;
      e.fo = 2'd2; e.dop = 2'd2; e.eo = 2'd2;
      e.sc = 0; e.mc = 0; e.err = 1'b0;
    end else begin
      e.redir = miss || (fetchPredTaken && !(mulDivBusy || dh));
      if (miss) begin
        e.fo = 2'd0; e.dop = 2'd2; e.eo = (c == 1) ? 2'd2 : 2'd0;
      end else if (mulDivBusy) begin
        e.fo = 2'd1; e.dop = 2'd1; e.eo = 2'd1;
      end else if (dh) begin
        e.fo = 2'd1; e.dop = 2'd1; e.eo = 2'd2;
      end else begin
        e.fo = 2'd0; e.dop = m_sh[c] ? 2'd2 : 2'd0; e.eo = 2'd0;
      end
      e.sc = m_sc[c]; e.mc = m_mc[c]; e.err = m_err[c];
    end
    return e;
  endfunction

  function automatic void advance(input int c);
    logic [31:0] v1, v2;
    logic dh, miss;
    int cmax, wl;
    cmax = (c == 1) ? 15 : 65535;
    wl   = (c == 1) ? 5 : 64;
    ref_hazards(v1, v2, dh, miss);
    if (!rstN) begin
      m_sh[c] = 1'b0; m_err[c] = 1'b0; m_wd[c] = 0; m_sc[c] = 0; m_mc[c] = 0;
    end else begin
      if (miss) m_sh[c] = 1'b0;
      else if (!(mulDivBusy || dh)) m_sh[c] = fetchPredTaken;
      if (mulDivBusy && !miss) begin
        if (m_wd[c] < wl) m_wd[c]++;
        if (m_wd[c] == wl) m_err[c] = 1'b1;
      end else begin
        m_wd[c] = 0;
      end
      if ((mulDivBusy || dh) && !miss && m_sc[c] < cmax) m_sc[c]++;
      if (miss && m_mc[c] < cmax) m_mc[c]++;
    end
  endfunction

  task automatic compare_outputs();
    exp_t ea, eb;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check("a_byp1", a_byp1, ea.byp1);  check("b_byp1", b_byp1, eb.byp1);
    check("a_byp2", a_byp2, ea.byp2);  check("b_byp2", b_byp2, eb.byp2);
    check("a_redirect", 32'(a_redir), 32'(ea.redir));
    check("b_redirect", 32'(b_redir), 32'(eb.redir));
    check("a_irregPc", a_pc, ea.pc);   check("b_irregPc", b_pc, eb.pc);
    check("a_fetchOp", 32'(a_fo), 32'(ea.fo));    check("b_fetchOp", 32'(b_fo), 32'(eb.fo));
    check("a_decodeOp", 32'(a_do), 32'(ea.dop));  check("b_decodeOp", 32'(b_do), 32'(eb.dop));
    check("a_executeOp", 32'(a_eo), 32'(ea.eo));  check("b_executeOp", 32'(b_eo), 32'(eb.eo));
    check("a_mulDivClear", 32'(a_mdc), 32'(ea.mdc));
    check("b_mulDivClear", 32'(b_mdc), 32'(eb.mdc));
    check("a_stallCount", 32'(a_sc), ea.sc);  check("b_stallCount", 32'(b_sc), eb.sc);
    check("a_missCount", 32'(a_mc), ea.mc);   check("b_missCount", 32'(b_mc), eb.mc);
    check("a_watchdogErr", 32'(a_err), 32'(ea.err));
    check("b_watchdogErr", 32'(b_err), 32'(eb.err));
  endtask

  // One cycle: push expectations for current inputs, compare on negedge, advance model.
  task automatic step();
    q_a.push_back(predict(0));
    q_b.push_back(predict(1));
    @(negedge clk);
    compare_outputs();
    advance(0);
    advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1Addr = 5'd1; rs2Addr = 5'd2; rs1Used = 1'b1; rs2Used = 1'b1;
    rs1Data = 32'h1111_0001; rs2Data = 32'h2222_0002;
    fwdValid = 2'b00; fwdReady = 2'b11; fwdAddr = 10'd0; fwdData = 64'd0;
    fetchPredTaken = 1'b0; fetchPredTarget = 32'h0000_0040;
    resValid = 1'b0; resTaken = 1'b0; resPred = 1'b0;
    resTarget = 32'h0000_0100; resFallthrough = 32'h0000_0200;
    mulDivBusy = 1'b0;
  endtask

  task automatic set_load_use();
    fwdValid = 2'b01; fwdReady = 2'b10; fwdAddr = {5'd0, 5'd7};
    fwdData = {32'h0, 32'hDEAD_0007}; rs2Addr = 5'd7; rs2Used = 1'b1;
  endtask

  initial begin
    int a_sc_before;
    for (int c = 0; c < 2; c++) begin
      m_sh[c] = 1'b0; m_err[c] = 1'b0; m_wd[c] = 0; m_sc[c] = 0; m_mc[c] = 0;
    end
    idle_inputs();
    rstN = 1'b0;
    @(posedge clk); #1;
    step();
    check("rst_fetchOp_flush", 32'(a_fo), 32'd2);
    rstN = 1'b1;
    repeat (2) step();

    // Bypass priority and x0
    fwdValid = 2'b11; fwdReady = 2'b11; fwdAddr = {5'd5, 5'd5};
    fwdData = {32'h0000_BBBB, 32'h0000_AAAA}; rs1Addr = 5'd5;
    #1 check("byp_prio_youngest", a_byp1, 32'h0000_AAAA);
    step();
    fwdValid = 2'b10;
    #1 check("byp_mem_source", a_byp1, 32'h0000_BBBB);
    step();
    rs1Addr = 5'd0;
    #1 check("byp_x0", a_byp1, 32'd0);
    step();
    idle_inputs();

    // Load-use on rs2, then operand unused
    set_load_use();
    #1 check("loaduse_execute_bubble", 32'(a_eo), 32'd2);
    repeat (3) step();
    rs2Used = 1'b0;
    step();
    idle_inputs();

    // Misprediction taken then not-taken
    resValid = 1'b1; resTaken = 1'b1; resPred = 1'b0;
    #1 check("miss_pc", a_pc, 32'h0000_0100);
    check("miss_exec_rs1", 32'(a_eo), 32'd0);
    check("miss_exec_rs2", 32'(b_eo), 32'd2);
    step();
    resTaken = 1'b0; resPred = 1'b1;
    step();
    idle_inputs();
    step();

    // Predicted taken, then shadow flush
    fetchPredTaken = 1'b1;
    step();
    fetchPredTaken = 1'b0;
    #1 check("shadow_decode_flush", 32'(a_do), 32'd2);
    repeat (2) step();
    // Predicted taken, then data hazard: shadow held through the stall
    fetchPredTaken = 1'b1;
    step();
    fetchPredTaken = 1'b0;
    set_load_use();
    repeat (2) step();
    idle_inputs();
    repeat (2) step();
    // Predicted taken during stall: no redirect
    fetchPredTaken = 1'b1;
    set_load_use();
    repeat (2) step();
    idle_inputs();
    step();

    // Watchdog: 64 busy cycles
    mulDivBusy = 1'b1;
    repeat (63) step();
    check("wdog_not_yet", 32'(a_err), 32'd0);
    step();
    check("wdog_trip", 32'(a_err), 32'd1);
    repeat (3) step();
    mulDivBusy = 1'b0;
    repeat (2) step();
    check("wdog_sticky", 32'(a_err), 32'd1);
    // Reset asserted mid-stall
    mulDivBusy = 1'b1;
    repeat (3) step();
    rstN = 1'b0;
    #1 check("rst_clears_err", 32'(a_err), 32'd0);
    step();
    rstN = 1'b1;
    repeat (4) step();
    mulDivBusy = 1'b0;
    step();

    // Saturation of 4-bit counter
    set_load_use();
    repeat (20) step();
    check("stall_sat_b", 32'(b_sc), 32'd15);
    idle_inputs();
    // Miss coincident with mulDivBusy
    a_sc_before = int'(a_sc);
    mulDivBusy = 1'b1; resValid = 1'b1; resTaken = 1'b1; resPred = 1'b0;
    step();
    check("miss_over_busy_no_stallcnt", 32'(a_sc), 32'(a_sc_before));
    idle_inputs();
    step();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rstN = ($urandom_range(0, 60) != 0);
      rs1Addr = 5'($urandom_range(0, 3)); rs2Addr = 5'($urandom_range(0, 3));
      rs1Used = 1'($urandom); rs2Used = 1'($urandom);
      rs1Data = $urandom; rs2Data = $urandom;
      fwdValid = 2'($urandom); fwdReady = 2'($urandom);
      fwdAddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwdData = {$urandom, $urandom};
      fetchPredTaken = 1'($urandom); fetchPredTarget = $urandom;
      resValid = ($urandom_range(0, 3) == 0); resTaken = 1'($urandom); resPred = 1'($urandom);
      resTarget = $urandom; resFallthrough = $urandom;
      mulDivBusy = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
